// File: rtl/reset_seq_ctrl.sv
// Post-reset bring-up sequencer: enables downstream stages one at a time, waits for each ack,
// and on ack timeout or ack loss requests a fresh reset from the generator, up to a retry limit.
module reset_seq_ctrl #(
  parameter int N_STAGE   = 3,
  parameter int WAIT_CYC  = 100,
  parameter int TIMEOUT   = 10000,
  parameter int MAX_RETRY = 3,
  parameter int REQ_LEN   = 16,
  parameter int CNT_W     = 16
) (
  input  logic               clk_100,
  input  logic               rst,
  input  logic               rst_done,
  input  logic [N_STAGE-1:0] stage_ack,
  output logic [N_STAGE-1:0] stage_en,
  output logic               rst_req,
  output logic               sys_ready,
  output logic               fail,
  output logic [1:0]         retry_cnt,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_ACK_WAIT = 3'd2,
    S_READY    = 3'd3,
    S_REQ_RST  = 3'd4,
    S_DROP     = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REQ_LAST  = CNT_W'(REQ_LEN - 1);
  localparam logic [1:0]       LAST_IDX  = 2'(N_STAGE - 1);
  localparam logic [1:0]       MAX_R     = 2'(MAX_RETRY);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [N_STAGE-1:0] en_q, en_d;
  logic               req_q, req_d;
  logic               rdy_q, rdy_d;
  logic               fail_q, fail_d;
  logic [1:0]         retry_q, retry_d;

  logic [N_STAGE-1:0] stage_bit;
  logic               ack_hit;
  logic               ack_lost;
  logic               abort;
  logic               escalate;

  // Only the stage currently being brought up can complete the handshake.
  assign stage_bit = N_STAGE'(1) << idx_q;
  assign ack_hit   = |(stage_ack & stage_bit);
  assign ack_lost  = (stage_ack & en_q) != en_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    en_d     = en_q;
    req_d    = req_q;
    rdy_d    = rdy_q;
    fail_d   = fail_q;
    retry_d  = retry_q;
    abort    = 1'b0;
    escalate = 1'b0;

    case (state_q)
      S_IDLE: begin
        en_d = '0;
        if (rst_done) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_WAIT: begin
        if (!rst_done) abort = 1'b1;
        else if (cnt_q == WAIT_LAST) begin
          en_d    = en_q | stage_bit;
          cnt_d   = '0;
          state_d = S_ACK_WAIT;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_ACK_WAIT: begin
        // Ack beats a timeout landing on the same cycle.
        if (!rst_done) abort = 1'b1;
        else if (ack_hit) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_READY;
            rdy_d   = 1'b1;
          end else begin
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end else if (cnt_q == TO_LAST) escalate = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
      S_READY: begin
        if (!rst_done) abort = 1'b1;
        else if (ack_lost) escalate = 1'b1;
      end
      S_REQ_RST: begin
        if (cnt_q == REQ_LAST) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_DROP;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_DROP: begin
        if (!rst_done) state_d = S_IDLE;
      end
      S_FAIL: begin
        en_d  = '0;
        req_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      en_d    = '0;
      rdy_d   = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (escalate) begin
      en_d  = '0;
      rdy_d = 1'b0;
      cnt_d = '0;
      if (retry_q < MAX_R) begin
        state_d = S_REQ_RST;
        req_d   = 1'b1;
        retry_d = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
      end else begin
        state_d = S_FAIL;
        fail_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      req_q   <= 1'b0;
      rdy_q   <= 1'b0;
      fail_q  <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      req_q   <= req_d;
      rdy_q   <= rdy_d;
      fail_q  <= fail_d;
      retry_q <= retry_d;
    end
  end

  assign stage_en  = en_q;
  assign rst_req   = req_q;
  assign sys_ready = rdy_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl with short timing parameters; expected values are
// hand-counted in clock edges from each stimulus change.
module tb_reset_seq_ctrl;

  logic       clk_100 = 1'b0;
  logic       rst;
  logic       rst_done;
  logic [2:0] stage_ack;
  logic [2:0] stage_en;
  logic       rst_req;
  logic       sys_ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;

  reset_seq_ctrl #(
    .N_STAGE(3), .WAIT_CYC(4), .TIMEOUT(16), .MAX_RETRY(2), .REQ_LEN(8), .CNT_W(16)
  ) dut (
    .clk_100  (clk_100),
    .rst      (rst),
    .rst_done (rst_done),
    .stage_ack(stage_ack),
    .stage_en (stage_en),
    .rst_req  (rst_req),
    .sys_ready(sys_ready),
    .fail     (fail),
    .retry_cnt(retry_cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk_100 = ~clk_100;

  // Advance n rising edges; inputs set afterwards are sampled on the following edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_100);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rst_done = 1'b0; stage_ack = 3'b000;
    tick(2);
    chk("rst_en", 8'(stage_en), 8'h0);
    chk("rst_req", 8'(rst_req), 8'h0);
    chk("rst_rdy", 8'(sys_ready), 8'h0);
    chk("rst_fail", 8'(fail), 8'h0);
    chk("rst_retry", 8'(retry_cnt), 8'h0);
    rst = 1'b0;

    // 1: normal bring-up, each ack two cycles after its enable
    rst_done = 1'b1;
    tick(4); chk("t1_en_pre0", 8'(stage_en), 8'h0);
    tick(1); chk("t1_en0", 8'(stage_en), 8'h1);
    tick(2); stage_ack = 3'b001;
    tick(4); chk("t1_en_pre1", 8'(stage_en), 8'h1);
    tick(1); chk("t1_en1", 8'(stage_en), 8'h3);
    tick(2); stage_ack = 3'b011;
    tick(4); chk("t1_en_pre2", 8'(stage_en), 8'h3);
    tick(1); chk("t1_en2", 8'(stage_en), 8'h7);
    chk("t1_rdy_pre", 8'(sys_ready), 8'h0);
    tick(2); stage_ack = 3'b111;
    tick(1); chk("t1_rdy", 8'(sys_ready), 8'h1);
    chk("t1_retry", 8'(retry_cnt), 8'h0);
    chk("t1_req", 8'(rst_req), 8'h0);

    // READY, then rst_done drops
    rst_done = 1'b0;
    tick(1); chk("t1_drop_rdy", 8'(sys_ready), 8'h0);
    chk("t1_drop_en", 8'(stage_en), 8'h0);

    // 2: stage 1 never acks; stage 0 ack is early (already high)
    stage_ack = 3'b001; rst_done = 1'b1;
    tick(5); chk("t2_en0", 8'(stage_en), 8'h1);
    tick(5); chk("t2_en1", 8'(stage_en), 8'h3);
    tick(15); chk("t2_req_pre", 8'(rst_req), 8'h0);
    chk("t2_en_pre", 8'(stage_en), 8'h3);
    tick(1); chk("t2_req_on", 8'(rst_req), 8'h1);
    chk("t2_en_clr", 8'(stage_en), 8'h0);
    chk("t2_retry", 8'(retry_cnt), 8'h1);
    tick(7); chk("t2_req_last", 8'(rst_req), 8'h1);
    tick(1); chk("t2_req_off", 8'(rst_req), 8'h0);
    tick(3); chk("t2_drop_hold", 8'(stage_en), 8'h0);
    chk("t2_drop_req", 8'(rst_req), 8'h0);
    rst_done = 1'b0;
    tick(1); rst_done = 1'b1;
    tick(4); chk("t2_re_pre", 8'(stage_en), 8'h0);
    tick(1); chk("t2_re_en0", 8'(stage_en), 8'h1);
    chk("t2_re_retry", 8'(retry_cnt), 8'h1);
    stage_ack = 3'b011;
    tick(5); chk("t2_re_en1", 8'(stage_en), 8'h3);
    stage_ack = 3'b111;
    tick(5); chk("t2_re_en2", 8'(stage_en), 8'h7);
    tick(1); chk("t2_re_rdy", 8'(sys_ready), 8'h1);

    // 5: rst_done drops while READY with a non-zero retry count
    rst_done = 1'b0;
    tick(1); chk("t5_rdy", 8'(sys_ready), 8'h0);
    chk("t5_en", 8'(stage_en), 8'h0);
    chk("t5_retry", 8'(retry_cnt), 8'h1);

    // 4: stage 0 ack lands on the timeout cycle
    stage_ack = 3'b000; rst_done = 1'b1;
    tick(5); chk("t4_en0", 8'(stage_en), 8'h1);
    tick(15); stage_ack = 3'b001;
    tick(1); chk("t4_req", 8'(rst_req), 8'h0);
    chk("t4_retry", 8'(retry_cnt), 8'h1);
    tick(4); chk("t4_en1", 8'(stage_en), 8'h3);

    // 3: stage 1 never acks across three attempts
    rst = 1'b1; stage_ack = 3'b001; rst_done = 1'b0;
    tick(1); rst = 1'b0; rst_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(10); chk($sformatf("t3_en1_%0d", k), 8'(stage_en), 8'h3);
      tick(15); chk($sformatf("t3_req_pre_%0d", k), 8'(rst_req), 8'h0);
      tick(1);
      if (k < 2) begin
        chk($sformatf("t3_req_on_%0d", k), 8'(rst_req), 8'h1);
        chk($sformatf("t3_retry_%0d", k), 8'(retry_cnt), 8'(k + 1));
        chk($sformatf("t3_nofail_%0d", k), 8'(fail), 8'h0);
        tick(8); chk($sformatf("t3_req_off_%0d", k), 8'(rst_req), 8'h0);
        rst_done = 1'b0;
        tick(1); rst_done = 1'b1;
      end else begin
        chk("t3_fail", 8'(fail), 8'h1);
        chk("t3_fail_req", 8'(rst_req), 8'h0);
        chk("t3_fail_retry", 8'(retry_cnt), 8'h2);
      end
    end
    rst_done = 1'b0; tick(3); rst_done = 1'b1; tick(20);
    chk("t3_stuck_fail", 8'(fail), 8'h1);
    chk("t3_stuck_en", 8'(stage_en), 8'h0);
    chk("t3_stuck_req", 8'(rst_req), 8'h0);
    rst = 1'b1;
    tick(1); chk("t3_rst_fail", 8'(fail), 8'h0);
    chk("t3_rst_retry", 8'(retry_cnt), 8'h0);

    // 6: rst during the third cycle of a reset request pulse
    rst = 1'b0; stage_ack = 3'b001; rst_done = 1'b1;
    tick(25); tick(1); chk("t6_req_on", 8'(rst_req), 8'h1);
    chk("t6_retry", 8'(retry_cnt), 8'h1);
    tick(2); chk("t6_req_c3", 8'(rst_req), 8'h1);
    rst = 1'b1;
    tick(1); chk("t6_req_off", 8'(rst_req), 8'h0);
    chk("t6_retry_clr", 8'(retry_cnt), 8'h0);
    chk("t6_en_clr", 8'(stage_en), 8'h0);
    rst = 1'b0;
    tick(3); chk("t6_no_req", 8'(rst_req), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
